vga_timing_gen: RTL and testbench

//  Parametrised VGA sync/timing generator, successor to the fixed 640x480@72Hz generator.
//  - Generates hsync, vsync, activevideo and pixel coordinates for any mode.
//  - Adds clock-enable, programmable sync polarity, line/frame strobes and blanking flags.
//  - All outputs are registered and cycle-aligned.
//  - Sits between the pixel-clock PLL and the game/pixel renderer.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_axis_counter.sv | 48 ++++
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: sync polarities and supported video modes.
package vga_timing_pkg;

  localparam int SYNC_ACT_LOW  = 0;
  localparam int SYNC_ACT_HIGH = 1;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    int hsync_pol;
    int vsync_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_72 = '{
    h_active: 640, h_fp: 24, h_sync: 40, h_bp: 128,
    v_active: 480, v_fp: 9,  v_sync: 3,  v_bp: 28,
    hsync_pol: SYNC_ACT_LOW, vsync_pol: SYNC_ACT_LOW
  };

  localparam vga_mode_t MODE_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    hsync_pol: SYNC_ACT_LOW, vsync_pol: SYNC_ACT_LOW
  };

  // Blanking interval is front porch + sync + back porch; it precedes the active region.
  function automatic int axis_blank(input int fp, input int sync, input int bp);
    return fp + sync + bp;
  endfunction

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return axis_blank(fp, sync, bp) + active;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping position counter plus sync/blank decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 24,
  parameter int SYNC   = 40,
  parameter int BP     = 128,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_raw,
  output logic         blank
);

  localparam int BLANK = axis_blank(FP, SYNC, BP);
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] BLANK_W    = W'(BLANK);
  localparam logic [W-1:0] SYNC_START = W'(FP);
  localparam logic [W-1:0] SYNC_END   = W'(FP + SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

  assign wrap  = (count == LAST);
  assign blank = (count < BLANK_W);

  // With no front porch the lower bound is always true, so it is dropped to keep the compare meaningful.
  generate
    if (FP == 0) begin : g_sync_at_zero
      assign sync_raw = (count < SYNC_END);
    end else begin : g_sync_after_fp
      assign sync_raw = (count >= SYNC_START) && (count < SYNC_END);
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator with pixel enable, sync polarity, strobes and blanking flags.
// Define VGA_TIMING_FRAMECNT_EN to enable the completed-frame counter on frame_count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W     = 10,
  parameter int H_ACTIVE  = MODE_640X480_72.h_active,
  parameter int H_FP      = MODE_640X480_72.h_fp,
  parameter int H_SYNC    = MODE_640X480_72.h_sync,
  parameter int H_BP      = MODE_640X480_72.h_bp,
  parameter int V_ACTIVE  = MODE_640X480_72.v_active,
  parameter int V_FP      = MODE_640X480_72.v_fp,
  parameter int V_SYNC    = MODE_640X480_72.v_sync,
  parameter int V_BP      = MODE_640X480_72.v_bp,
  parameter int HSYNC_POL = MODE_640X480_72.hsync_pol,
  parameter int VSYNC_POL = MODE_640X480_72.vsync_pol,
  parameter int FRAME_W   = 8
) (
  input  logic               px_clk,
  input  logic               reset,
  input  logic               px_en,
  output logic               hsync,
  output logic               vsync,
  output logic               activevideo,
  output logic [CNT_W-1:0]   x_px,
  output logic [CNT_W-1:0]   y_px,
  output logic               hblank,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_BLANK = axis_blank(H_FP, H_SYNC, H_BP);
  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_BLANK = axis_blank(V_FP, V_SYNC, V_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_BLANK_W = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] V_BLANK_W = CNT_W'(V_BLANK);
  localparam logic             HS_ACT    = (HSYNC_POL != 0);
  localparam logic             VS_ACT    = (VSYNC_POL != 0);

  generate
    if (H_TOTAL > (1 << CNT_W)) begin : g_h_too_wide
      $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_v_too_wide
      $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
  endgenerate

  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_sync_raw;
  logic             v_sync_raw;
  logic             h_blank;
  logic             v_blank;
  logic             v_en;
  logic             active;

  assign v_en = px_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CNT_W)
  ) u_h_axis (
    .clk     (px_clk),
    .rst_n   (reset),
    .en      (px_en),
    .count   (h_count),
    .wrap    (h_wrap),
    .sync_raw(h_sync_raw),
    .blank   (h_blank)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CNT_W)
  ) u_v_axis (
    .clk     (px_clk),
    .rst_n   (reset),
    .en      (v_en),
    .count   (v_count),
    .wrap    (v_wrap),
    .sync_raw(v_sync_raw),
    .blank   (v_blank)
  );

  assign active = !h_blank && !v_blank;

  // Every output is decoded from the same (h_count, v_count) on the same edge, so nothing is skewed.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      activevideo <= 1'b0;
      x_px        <= '0;
      y_px        <= '0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (px_en) begin
      hsync       <= h_sync_raw ? HS_ACT : ~HS_ACT;
      vsync       <= v_sync_raw ? VS_ACT : ~VS_ACT;
      activevideo <= active;
      x_px        <= active ? (h_count - H_BLANK_W) : '0;
      y_px        <= active ? (v_count - V_BLANK_W) : '0;
      hblank      <= h_blank;
      vblank      <= v_blank;
      line_start  <= (h_count == '0);
      frame_start <= (h_count == '0) && (v_count == '0);
    end
  end

`ifdef VGA_TIMING_FRAMECNT_EN
  logic               frame_done_reg;
  logic [FRAME_W-1:0] frame_count_reg;

  // The last pixel is flagged first; the increment lands with the following (0,0) pixel so it lines up with frame_start.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else if (px_en) begin
      frame_done_reg <= h_wrap & v_wrap;
      if (frame_done_reg) begin
        frame_count_reg <= frame_count_reg + FRAME_W'(1);
      end
    end
  end

  assign frame_count = frame_count_reg;
`else
  logic unused_v_wrap;

  assign unused_v_wrap = v_wrap;
  assign frame_count   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised px_en bench for vga_timing_gen: two small modes (one with zero porches, active-high syncs) vs a pixel-index model.
module tb_vga_timing_gen;

  localparam int A_HFP = 2, A_HS = 3, A_HBP = 2, A_HA = 8;
  localparam int A_VFP = 1, A_VS = 2, A_VBP = 1, A_VA = 4;
  localparam int A_W = 5, A_FW = 2;
  localparam int B_HFP = 0, B_HS = 2, B_HBP = 1, B_HA = 5;
  localparam int B_VFP = 0, B_VS = 1, B_VBP = 2, B_VA = 3;
  localparam int B_W = 4, B_FW = 3;

  typedef struct {
    logic hsync, vsync, av, hb, vb, ls, fs;
    int   x, y, fc;
  } exp_t;

  logic px_clk = 1'b0;
  logic reset;
  logic px_en;

  logic            a_hsync, a_vsync, a_av, a_hb, a_vb, a_ls, a_fs;
  logic [A_W-1:0]  a_x, a_y;
  logic [A_FW-1:0] a_fc;
  logic            b_hsync, b_vsync, b_av, b_hb, b_vb, b_ls, b_fs;
  logic [B_W-1:0]  b_x, b_y;
  logic [B_FW-1:0] b_fc;

  int     checks = 0;
  int     fails  = 0;
  int     cyc    = -1;
  bit     valid;
  longint next_p;
  longint cur_p;

  always #5 px_clk = ~px_clk;

  vga_timing_gen #(
    .CNT_W(A_W), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .HSYNC_POL(0), .VSYNC_POL(0), .FRAME_W(A_FW)
  ) dut_a (
    .px_clk(px_clk), .reset(reset), .px_en(px_en),
    .hsync(a_hsync), .vsync(a_vsync), .activevideo(a_av),
    .x_px(a_x), .y_px(a_y), .hblank(a_hb), .vblank(a_vb),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .CNT_W(B_W), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .HSYNC_POL(1), .VSYNC_POL(1), .FRAME_W(B_FW)
  ) dut_b (
    .px_clk(px_clk), .reset(reset), .px_en(px_en),
    .hsync(b_hsync), .vsync(b_vsync), .activevideo(b_av),
    .x_px(b_x), .y_px(b_y), .hblank(b_hb), .vblank(b_vb),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  // Expected outputs for the p-th pixel shown since reset (valid=0: nothing shown yet).
  function automatic exp_t expect_px(input bit v, input longint p,
                                     input int hfp, input int hs, input int hbp, input int ha,
                                     input int vfp, input int vs, input int vbp, input int va,
                                     input bit hpol, input bit vpol, input int fw);
    exp_t   e;
    int     hbl = hfp + hs + hbp;
    int     vbl = vfp + vs + vbp;
    int     ht  = hbl + ha;
    int     vt  = vbl + va;
    longint fr  = longint'(ht) * longint'(vt);
    int     q, hc, vc;
    e = '{hsync: !hpol, vsync: !vpol, av: 1'b0, hb: 1'b0, vb: 1'b0, ls: 1'b0, fs: 1'b0,
          x: 0, y: 0, fc: 0};
    if (!v) return e;
    q  = int'(p % fr);
    hc = q % ht;
    vc = q / ht;
    e.hsync = (hc >= hfp && hc < hfp + hs) ? hpol : !hpol;
    e.vsync = (vc >= vfp && vc < vfp + vs) ? vpol : !vpol;
    e.av    = (hc >= hbl) && (vc >= vbl);
    e.x     = e.av ? hc - hbl : 0;
    e.y     = e.av ? vc - vbl : 0;
    e.hb    = (hc < hbl);
    e.vb    = (vc < vbl);
    e.ls    = (hc == 0);
    e.fs    = (hc == 0) && (vc == 0);
`ifdef VGA_TIMING_FRAMECNT_EN
    e.fc    = int'((p / fr) % (longint'(1) << fw));
`else
    e.fc    = 0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_both();
    exp_t ea, eb;
    ea = expect_px(valid, cur_p, A_HFP, A_HS, A_HBP, A_HA, A_VFP, A_VS, A_VBP, A_VA, 1'b0, 1'b0, A_FW);
    eb = expect_px(valid, cur_p, B_HFP, B_HS, B_HBP, B_HA, B_VFP, B_VS, B_VBP, B_VA, 1'b1, 1'b1, B_FW);
    chk("a.hsync", 32'(a_hsync), 32'(ea.hsync));
    chk("a.vsync", 32'(a_vsync), 32'(ea.vsync));
    chk("a.activevideo", 32'(a_av), 32'(ea.av));
    chk("a.x_px", 32'(a_x), 32'(ea.x));
    chk("a.y_px", 32'(a_y), 32'(ea.y));
    chk("a.hblank", 32'(a_hb), 32'(ea.hb));
    chk("a.vblank", 32'(a_vb), 32'(ea.vb));
    chk("a.line_start", 32'(a_ls), 32'(ea.ls));
    chk("a.frame_start", 32'(a_fs), 32'(ea.fs));
    chk("a.frame_count", 32'(a_fc), 32'(ea.fc));
    chk("b.hsync", 32'(b_hsync), 32'(eb.hsync));
    chk("b.vsync", 32'(b_vsync), 32'(eb.vsync));
    chk("b.activevideo", 32'(b_av), 32'(eb.av));
    chk("b.x_px", 32'(b_x), 32'(eb.x));
    chk("b.y_px", 32'(b_y), 32'(eb.y));
    chk("b.hblank", 32'(b_hb), 32'(eb.hb));
    chk("b.vblank", 32'(b_vb), 32'(eb.vb));
    chk("b.line_start", 32'(b_ls), 32'(eb.ls));
    chk("b.frame_start", 32'(b_fs), 32'(eb.fs));
    chk("b.frame_count", 32'(b_fc), 32'(eb.fc));
  endtask

  initial begin
    reset  = 1'b0;
    px_en  = 1'b0;
    valid  = 1'b0;
    next_p = 0;
    cur_p  = 0;
    repeat (3) @(posedge px_clk);
    @(negedge px_clk);
    check_both();
    $display("reset state checked, releasing reset");
    reset = 1'b1;

    for (int c = 0; c < 2600; c++) begin
      cyc = c;
      if (c < 700)       px_en = 1'b1;
      else if (c < 1500) px_en = ((c % 3) == 0);
      else               px_en = ($urandom_range(0, 3) != 0);
      @(posedge px_clk);
      if (px_en) begin
        valid = 1'b1;
        cur_p = next_p;
        next_p++;
      end
      @(negedge px_clk);
      check_both();
      if (a_fs === 1'b1 && px_en)
        $display("cycle %0d frame_start pixel %0d frame_count a=%0d b=%0d", c, cur_p, a_fc, b_fc);

      if (c == 1000 || c == 2000) begin
        reset = 1'b0;
        #1;
        valid  = 1'b0;
        next_p = 0;
        cur_p  = 0;
        check_both();
        px_en = 1'b1;
        @(posedge px_clk);
        @(negedge px_clk);
        check_both();
        $display("cycle %0d reset pulse checked", c);
        reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
